// File: rtl/nv_nvdla_glb_intr_coalesce.sv
// nv_nvdla_glb_intr_coalesce: W1C done-status collector with mask and coalescing interrupt FSM
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   done_pd       : done pulses, bit 2i = source i group0, bit 2i+1 = group1
//   reg_req_*     : register request (always ready), reg_resp_* : response one cycle later
//   core_intr     : registered level interrupt, high while the FSM is in FIRE
// Optional feature: define NVDLA_GLB_PERF_CNT_EN for per-source done counters at 0x10+i.
module nv_nvdla_glb_intr_coalesce #(
    parameter int NUM_SRC = 8,
    parameter int TMO_W   = 16
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [2*NUM_SRC-1:0] done_pd,
    input  logic                 reg_req_vld,
    output logic                 reg_req_rdy,
    input  logic                 reg_req_wr,
    input  logic [7:0]           reg_req_addr,
    input  logic [31:0]          reg_req_wdat,
    output logic                 reg_resp_vld,
    output logic [31:0]          reg_resp_rdat,
    output logic                 core_intr
);
    localparam int NB = 2 * NUM_SRC;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FIRE = 2'd2} state_t;
    state_t           state_q;
    logic [NB-1:0]    status_q, status_d, mask_q, mask_d, set_bits;
    logic [7:0]       thresh_q, thresh_d, pend_q, pend_sat, thr_eff;
    logic [TMO_W-1:0] tmo_q, tmo_d, timer_q;
    logic [5:0]       ev_cnt;
    logic [8:0]       pend_sum;
    logic [31:0]      rdat_q, rdat_d, perf_rd;
    logic             wr, unmasked, fire_hit, core_intr_q, resp_vld_q;
    logic             unused_wdat;
    assign wr            = reg_req_vld & reg_req_wr;
    assign reg_req_rdy   = 1'b1;
    assign reg_resp_vld  = resp_vld_q;
    assign reg_resp_rdat = rdat_q;
    assign core_intr     = core_intr_q;
    assign unused_wdat   = ^reg_req_wdat;
    always_comb begin
        set_bits = done_pd | ((wr && reg_req_addr == 8'h01) ? reg_req_wdat[NB-1:0] : '0);
        // set is OR-ed after the clear so a same-cycle set wins
        status_d = (status_q & ~((wr && reg_req_addr == 8'h02) ? reg_req_wdat[NB-1:0] : '0)) | set_bits;
        mask_d   = (wr && reg_req_addr == 8'h00) ? reg_req_wdat[NB-1:0] : mask_q;
        thresh_d = (wr && reg_req_addr == 8'h03) ? reg_req_wdat[7:0] : thresh_q;
        tmo_d    = (wr && reg_req_addr == 8'h03) ? reg_req_wdat[TMO_W+7:8] : tmo_q;
        ev_cnt   = '0;
        for (int i = 0; i < NB; i++) ev_cnt = ev_cnt + 6'(set_bits[i] & ~mask_q[i]);
        pend_sum = {1'b0, pend_q} + 9'(ev_cnt);
        pend_sat = pend_sum[8] ? 8'hFF : pend_sum[7:0];
        thr_eff  = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
        unmasked = |(status_q & ~mask_q);
        fire_hit = (pend_q >= thr_eff) || (tmo_q != '0 && timer_q == tmo_q - TMO_W'(1));
    end
    always_comb begin
        rdat_d = '0;
        if (reg_req_vld && !reg_req_wr) begin
            case (reg_req_addr)
                8'h00:   rdat_d = 32'(mask_q);
                8'h02:   rdat_d = 32'(status_q);
                8'h03:   rdat_d = 32'({tmo_q, thresh_q});
                8'h04:   rdat_d = {22'd0, state_q, pend_q};
                default: rdat_d = perf_rd;
            endcase
        end
    end
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            status_q   <= '0;
            mask_q     <= '0;
            thresh_q   <= 8'd1;
            tmo_q      <= '0;
            resp_vld_q <= 1'b0;
            rdat_q     <= '0;
        end else begin
            status_q   <= status_d;
            mask_q     <= mask_d;
            thresh_q   <= thresh_d;
            tmo_q      <= tmo_d;
            resp_vld_q <= reg_req_vld;
            rdat_q     <= rdat_d;
        end
    end
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pend_q      <= '0;
            core_intr_q <= 1'b0;
        end else begin
            pend_q <= pend_sat;
            case (state_q)
                IDLE: if (unmasked) begin
                    state_q <= ACCUM;
                    timer_q <= '0;
                end
                ACCUM: if (!unmasked) begin
                    state_q <= IDLE;
                    pend_q  <= '0;
                end else if (fire_hit) begin
                    state_q     <= FIRE;
                    core_intr_q <= 1'b1;
                end else begin
                    timer_q <= timer_q + TMO_W'(1);
                end
                FIRE: if (!unmasked) begin
                    state_q     <= IDLE;
                    pend_q      <= '0;
                    core_intr_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    pend_q      <= '0;
                    core_intr_q <= 1'b0;
                end
            endcase
        end
    end
`ifdef NVDLA_GLB_PERF_CNT_EN
    logic [31:0] perf_q [NUM_SRC];
    always_comb begin
        perf_rd = '0;
        for (int i = 0; i < NUM_SRC; i++) if (reg_req_addr == 8'(16 + i)) perf_rd = perf_q[i];
    end
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_perf
        always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst) perf_q[i] <= '0;
            else if (wr && reg_req_addr == 8'(16 + i)) perf_q[i] <= '0;
            else if (|done_pd[2*i +: 2]) perf_q[i] <= perf_q[i] + 32'd1;
        end
    end
`else
    assign perf_rd = '0;
`endif
endmodule

// File: tb/tb_nv_nvdla_glb_intr_coalesce.sv
// tb_nv_nvdla_glb_intr_coalesce: directed self-checking bench for the coalescing interrupt controller
module tb_nv_nvdla_glb_intr_coalesce;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] done_pd = '0;
    logic        vld = 1'b0, wr = 1'b0, rdy, resp_vld, core_intr;
    logic [7:0]  addr = '0;
    logic [31:0] wdat = '0, resp_rdat, d;
    int          n_tests = 0, n_fail = 0;
`ifdef NVDLA_GLB_PERF_CNT_EN
    localparam logic [31:0] PERF_EXP = 32'd300;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif
    nv_nvdla_glb_intr_coalesce #(.NUM_SRC(8), .TMO_W(16)) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .done_pd(done_pd),
        .reg_req_vld(vld),
        .reg_req_rdy(rdy),
        .reg_req_wr(wr),
        .reg_req_addr(addr),
        .reg_req_wdat(wdat),
        .reg_resp_vld(resp_vld),
        .reg_resp_rdat(resp_rdat),
        .core_intr(core_intr)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic reg_wr(input logic [7:0] a, input logic [31:0] w);
        vld = 1'b1; wr = 1'b1; addr = a; wdat = w;
        tick();
        vld = 1'b0; wr = 1'b0;
        check("wr_resp_vld", 32'(resp_vld), 32'd1);
        check("wr_rdat", resp_rdat, 32'd0);
    endtask
    task automatic reg_rd(input logic [7:0] a, output logic [31:0] r);
        vld = 1'b1; wr = 1'b0; addr = a;
        tick();
        vld = 1'b0;
        check("rd_resp_vld", 32'(resp_vld), 32'd1);
        r = resp_rdat;
    endtask
    initial begin
        // 1: reset values
        repeat (3) tick();
        check("rst_intr", 32'(core_intr), 32'd0);
        check("rst_resp_vld", 32'(resp_vld), 32'd0);
        check("rst_rdat", resp_rdat, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_resp_vld", 32'(resp_vld), 32'd0);
        reg_rd(8'h00, d); check("rst_mask", d, 32'h0);
        reg_rd(8'h01, d); check("rst_set", d, 32'h0);
        reg_rd(8'h02, d); check("rst_status", d, 32'h0);
        reg_rd(8'h03, d); check("rst_coalesce", d, 32'h1);
        reg_rd(8'h04, d); check("rst_pend", d, 32'h0);
        reg_rd(8'h05, d); check("unmapped", d, 32'h0);
        // 2: single pulse on src2 group0 with thresh 1
        done_pd = 16'h0010;
        tick();
        done_pd = '0;
        check("t2_intr_c1", 32'(core_intr), 32'd0);
        tick();
        check("t2_intr_c2", 32'(core_intr), 32'd0);
        tick();
        check("t2_intr_c3", 32'(core_intr), 32'd1);
        reg_rd(8'h02, d); check("t2_status", d, 32'h10);
        reg_wr(8'h02, 32'h10);
        check("t2_intr_w1", 32'(core_intr), 32'd1);
        tick();
        check("t2_intr_w2", 32'(core_intr), 32'd0);
        reg_rd(8'h02, d); check("t2_status_clr", d, 32'h0);
        // 3: thresh 4, timeout 10; three pulses fire via timer
        reg_wr(8'h03, 32'h0000_0A04);
        reg_rd(8'h03, d); check("t3_coalesce", d, 32'h0000_0A04);
        for (int k = 0; k < 12; k++) begin
            done_pd = (k == 0 || k == 3 || k == 6) ? 16'h0001 : 16'h0000;
            tick();
            if (k == 10) check("t3_tmo_early", 32'(core_intr), 32'd0);
        end
        done_pd = '0;
        check("t3_tmo_fire", 32'(core_intr), 32'd1);
        reg_wr(8'h02, 32'h1);
        tick();
        check("t3_tmo_clr", 32'(core_intr), 32'd0);
        reg_rd(8'h04, d); check("t3_pend_idle", d, 32'h0);
        // four back-to-back pulses fire on count
        for (int k = 0; k < 5; k++) begin
            done_pd = (k < 4) ? 16'h0001 : 16'h0000;
            tick();
            if (k == 3) check("t3_cnt_early", 32'(core_intr), 32'd0);
        end
        check("t3_cnt_fire", 32'(core_intr), 32'd1);
        reg_rd(8'h04, d); check("t3_pend_fire", d, 32'h0000_0204);
        reg_wr(8'h02, 32'h1);
        tick();
        // 4: masked bits latch but do not interrupt; thresh 1, timeout 2
        reg_wr(8'h03, 32'h0000_0201);
        reg_wr(8'h00, 32'h0000_FFFF);
        done_pd = 16'hFFFF;
        tick();
        done_pd = '0;
        repeat (3) tick();
        check("t4_masked_intr", 32'(core_intr), 32'd0);
        reg_rd(8'h02, d); check("t4_status", d, 32'h0000_FFFF);
        reg_rd(8'h04, d); check("t4_pend", d, 32'h0);
        reg_rd(8'h00, d); check("t4_mask", d, 32'h0000_FFFF);
        reg_wr(8'h00, 32'h0);
        tick();
        tick();
        check("t4_unmask_early", 32'(core_intr), 32'd0);
        tick();
        check("t4_unmask_fire", 32'(core_intr), 32'd1);
        reg_wr(8'h02, 32'h0000_FFFF);
        tick();
        check("t4_clr", 32'(core_intr), 32'd0);
        // 5: set beats same-cycle clear; SET register
        done_pd = 16'h0001; vld = 1'b1; wr = 1'b1; addr = 8'h02; wdat = 32'h1;
        tick();
        done_pd = '0; vld = 1'b0; wr = 1'b0;
        reg_rd(8'h02, d); check("t5_set_wins", d, 32'h1);
        reg_wr(8'h01, 32'h8);
        reg_rd(8'h02, d); check("t5_w1s", d, 32'h9);
        reg_wr(8'h02, 32'h9);
        tick();
        reg_rd(8'h02, d); check("t5_clr", d, 32'h0);
        // 6: per-source done counters
        reg_wr(8'h11, 32'h0);
        done_pd = 16'h0004;
        repeat (300) tick();
        done_pd = '0;
        reg_rd(8'h11, d); check("t6_perf_300", d, PERF_EXP);
        reg_wr(8'h11, 32'h0);
        reg_rd(8'h11, d); check("t6_perf_clr", d, 32'h0);
        done_pd = 16'h0008; vld = 1'b1; wr = 1'b1; addr = 8'h11; wdat = 32'h0;
        tick();
        done_pd = '0; vld = 1'b0; wr = 1'b0;
        reg_rd(8'h11, d); check("t6_clr_beats_inc", d, 32'h0);
        // reset mid-operation drops the in-flight response
        check("t7_pre_intr", 32'(core_intr), 32'd1);
        vld = 1'b1; addr = 8'h02; rst = 1'b1;
        tick();
        vld = 1'b0; rst = 1'b0;
        check("t7_rst_resp", 32'(resp_vld), 32'd0);
        check("t7_rst_intr", 32'(core_intr), 32'd0);
        reg_rd(8'h02, d); check("t7_rst_status", d, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
